// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULTU = 3'd0,
        OP_MULT  = 3'd1,
        OP_DIVU  = 3'd2,
        OP_DIV   = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [2*WIDTH-1:0]   opb,
    input  logic [WIDTH-1:0]     opm,
    output logic [2*WIDTH-1:0]   acc_nxt,
    output logic [2*WIDTH-1:0]   opb_nxt,
    output logic [WIDTH-1:0]     opm_nxt
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        acc_nxt = acc;
        opb_nxt = opb;
        opm_nxt = opm;
        // divide: acc = {remainder, quotient}; bit WIDTH of diff is the borrow
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opb[WIDTH-1:0]};
        if (div_mode) begin
            if (diff[WIDTH]) begin
                acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (opm[0]) begin
                acc_nxt = acc + opb;
            end
            opb_nxt = {opb[2*WIDTH-2:0], 1'b0};
            opm_nxt = {1'b0, opm[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative multiply/divide unit owning HI/LO.
// MULDIV_EARLY_EXIT_EN: multiply finishes once remaining multiplier bits are zero.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, opb, acc_nxt, opb_nxt;
    logic [WIDTH-1:0]   opm, opm_nxt;
    logic               is_div, neg_q, neg_r, dz;
    logic               launch;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div),
        .acc      (acc),
        .opb      (opb),
        .opm      (opm),
        .acc_nxt  (acc_nxt),
        .opb_nxt  (opb_nxt),
        .opm_nxt  (opm_nxt)
    );

    assign busy   = (state != ST_IDLE);
    assign launch = (state == ST_IDLE) && start && !flush && !op[2];

    always_comb begin
        mag_a = (op[0] && a[WIDTH-1]) ? -a : a;
        mag_b = (op[0] && b[WIDTH-1]) ? -b : b;
    end

    // opm keeps |dividend| during a divide so a zero divisor can return it
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (dz) begin
                res_hi = neg_r ? -opm : opm;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_FIN;
                end
`ifdef MULDIV_EARLY_EXIT_EN
                else if (!is_div && opm_nxt == '0) begin
                    state_nxt = ST_FIN;
                end
`endif
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            opm      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                                is_div <= op[1];
                                neg_q  <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r  <= op[0] && a[WIDTH-1];
                                dz     <= op[1] && (b == '0);
                                cnt    <= CNT_W'(WIDTH);
                                opm    <= op[1] ? mag_a : mag_b;
                                opb    <= {{WIDTH{1'b0}}, op[1] ? mag_b : mag_a};
                                acc    <= op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    acc <= acc_nxt;
                    opb <= opb_nxt;
                    opm <= opm_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                ST_FIN: begin
                    if (!flush) begin
                        hi       <= res_hi;
                        lo       <= res_lo;
                        done     <= 1'b1;
                        div_zero <= dz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
